// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and helpers for the alu_seq multi-pass sequencer.
package alu_seq_pkg;

  localparam logic [7:0] OP_NOP  = 8'd0;
  localparam logic [7:0] OP_ADD  = 8'd1;
  localparam logic [7:0] OP_ADC  = 8'd2;
  localparam logic [7:0] OP_SUB  = 8'd3;
  localparam logic [7:0] OP_SUC  = 8'd4;
  localparam logic [7:0] OP_MUL8 = 8'd5;
  localparam logic [7:0] OP_MUL6 = 8'd6;
  localparam logic [7:0] OP_DIV8 = 8'd7;
  localparam logic [7:0] OP_DIV6 = 8'd8;
  localparam logic [7:0] OP_CMP  = 8'd9;

  localparam logic [31:0] ERR_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE, P1_ISSUE, P1_CAP, P2_ISSUE, P2_CAP, RESP
  } state_e;

  function automatic logic is_muldiv(input logic [7:0] op);
    return (op == OP_MUL8) || (op == OP_MUL6) || (op == OP_DIV8) || (op == OP_DIV6);
  endfunction

  function automatic logic is_wide_op(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

  // MUL6/DIV6 return a 32-bit product / {remainder, quotient} spread over c and acc.
  function automatic logic [31:0] narrow_result(input logic [7:0] op,
                                                input logic [15:0] hi,
                                                input logic [15:0] lo);
    if (op == OP_CMP)
      return '0;
    else if ((op == OP_MUL6) || (op == OP_DIV6))
      return {hi, lo};
    else
      return {16'h0000, lo};
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request, response and ALU operand bundle; master = sequencer, slave = requester/ALU side.
interface alu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_op;
  logic        req_wide;
  logic        req_cf;
  logic [31:0] req_a;
  logic [31:0] req_b;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_c;
  logic        rsp_z;
  logic        rsp_o;
  logic        rsp_err;

  logic [7:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_cf;
  logic [15:0] alu_acc;
  logic [15:0] alu_c;
  logic        alu_c_flag;
  logic        alu_z_flag;
  logic        alu_o_flag;

  modport master (
    input  req_valid, req_op, req_wide, req_cf, req_a, req_b, rsp_ready,
           alu_acc, alu_c, alu_c_flag, alu_z_flag, alu_o_flag,
    output req_ready, rsp_valid, rsp_result, rsp_c, rsp_z, rsp_o, rsp_err,
           alu_op, alu_a, alu_b, alu_cf
  );

  modport slave (
    output req_valid, req_op, req_wide, req_cf, req_a, req_b, rsp_ready,
           alu_acc, alu_c, alu_c_flag, alu_z_flag, alu_o_flag,
    input  req_ready, rsp_valid, rsp_result, rsp_c, rsp_z, rsp_o, rsp_err,
           alu_op, alu_a, alu_b, alu_cf
  );
endinterface

// File: rtl/alu_seq_carry.sv
// Low-word chain bit for wide ops: unsigned carry-out for ADD, borrow (a < b) for SUB.
module alu_seq_carry (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        sub_i,
  output logic        chain_o
);
  logic [16:0] sum;

  assign sum     = {1'b0, a_i} + {1'b0, b_i};
  assign chain_o = sub_i ? (a_i < b_i) : sum[16];
endmodule

// File: rtl/alu_seq.sv
// Multi-pass sequencer in front of the 16-bit ALU; wide ADD/SUB/CMP
// chaining is built only when ALU_SEQ_WIDE_EN is defined.
module alu_seq
  import alu_seq_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.master bus
);

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_c_q, rsp_c_d, rsp_z_q, rsp_z_d, rsp_o_q, rsp_o_d, rsp_err_q, rsp_err_d;
  logic [7:0]  alu_op_q, alu_op_d;
  logic [15:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic        alu_cf_q, alu_cf_d;
  logic [7:0]  op_q, op_d;
  logic        bad_op, div0;

  assign bad_op = (bus.req_op == OP_NOP) || (bus.req_op > OP_CMP);
  assign div0   = ((bus.req_op == OP_DIV8) || (bus.req_op == OP_DIV6)) && (bus.req_b[15:0] == 16'h0000);

`ifdef ALU_SEQ_WIDE_EN
  logic        wide_q, wide_d, wide_req, chain;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [15:0] lo_acc_q, lo_acc_d;

  assign wide_req = bus.req_wide && is_wide_op(bus.req_op);

  // The ALU's own carry is sign-extended, so the chain bit is derived here.
  alu_seq_carry u_carry (
    .a_i     (a_q[15:0]),
    .b_i     (b_q[15:0]),
    .sub_i   (op_q == OP_SUB),
    .chain_o (chain)
  );
`endif

  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_c_d      = rsp_c_q;
    rsp_z_d      = rsp_z_q;
    rsp_o_d      = rsp_o_q;
    rsp_err_d    = rsp_err_q;
    alu_op_d     = OP_NOP;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cf_d     = alu_cf_q;
    op_d         = op_q;
`ifdef ALU_SEQ_WIDE_EN
    wide_d       = wide_q;
    a_d          = a_q;
    b_d          = b_q;
    lo_acc_d     = lo_acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          op_d = bus.req_op;
          if (bad_op || div0) begin
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            rsp_result_d = div0 ? ERR_RESULT : '0;
            rsp_err_d    = 1'b1;
            rsp_c_d      = 1'b0;
            rsp_z_d      = 1'b0;
            rsp_o_d      = 1'b0;
          end else begin
            state_d  = P1_ISSUE;
            alu_op_d = bus.req_op;
            alu_a_d  = bus.req_a[15:0];
            alu_b_d  = bus.req_b[15:0];
            alu_cf_d = bus.req_cf;
`ifdef ALU_SEQ_WIDE_EN
            wide_d = wide_req;
            a_d    = bus.req_a;
            b_d    = bus.req_b;
            if (wide_req) begin
              alu_cf_d = 1'b0;
              if (bus.req_op == OP_CMP) begin
                alu_a_d = bus.req_a[31:16];
                alu_b_d = bus.req_b[31:16];
              end
            end
`endif
          end
        end
      end
      P1_ISSUE: state_d = P1_CAP;
      P1_CAP: begin
        state_d      = RESP;
        rsp_valid_d  = 1'b1;
        rsp_err_d    = 1'b0;
        rsp_result_d = narrow_result(op_q, bus.alu_c, bus.alu_acc);
        rsp_z_d      = bus.alu_z_flag;
        rsp_c_d      = is_muldiv(op_q) ? 1'b0 : bus.alu_c_flag;
        rsp_o_d      = is_muldiv(op_q) ? 1'b0 : bus.alu_o_flag;
`ifdef ALU_SEQ_WIDE_EN
        if (wide_q) begin
          lo_acc_d = bus.alu_acc;
          if (op_q == OP_CMP) begin
            if (bus.alu_z_flag) begin
              state_d     = P2_ISSUE;
              rsp_valid_d = 1'b0;
              alu_op_d    = OP_CMP;
              alu_a_d     = a_q[15:0];
              alu_b_d     = b_q[15:0];
              alu_cf_d    = 1'b0;
            end
          end else begin
            state_d     = P2_ISSUE;
            rsp_valid_d = 1'b0;
            alu_op_d    = (op_q == OP_ADD) ? OP_ADC : OP_SUC;
            alu_a_d     = a_q[31:16];
            alu_b_d     = b_q[31:16];
            alu_cf_d    = chain;
          end
        end
`endif
      end
`ifdef ALU_SEQ_WIDE_EN
      P2_ISSUE: state_d = P2_CAP;
      P2_CAP: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_c_d     = bus.alu_c_flag;
        rsp_o_d     = bus.alu_o_flag;
        if (op_q == OP_CMP) begin
          rsp_result_d = '0;
          rsp_z_d      = bus.alu_z_flag;
        end else begin
          rsp_result_d = {bus.alu_acc, lo_acc_q};
          rsp_z_d      = (lo_acc_q == 16'h0000) && (bus.alu_acc == 16'h0000);
        end
      end
`endif
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_c_q      <= 1'b0;
      rsp_z_q      <= 1'b0;
      rsp_o_q      <= 1'b0;
      rsp_err_q    <= 1'b0;
      alu_op_q     <= OP_NOP;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cf_q     <= 1'b0;
      op_q         <= OP_NOP;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_c_q      <= rsp_c_d;
      rsp_z_q      <= rsp_z_d;
      rsp_o_q      <= rsp_o_d;
      rsp_err_q    <= rsp_err_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cf_q     <= alu_cf_d;
      op_q         <= op_d;
    end
  end

`ifdef ALU_SEQ_WIDE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wide_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      lo_acc_q <= '0;
    end else begin
      wide_q   <= wide_d;
      a_q      <= a_d;
      b_q      <= b_d;
      lo_acc_q <= lo_acc_d;
    end
  end
`endif

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_c      = rsp_c_q;
  assign bus.rsp_z      = rsp_z_q;
  assign bus.rsp_o      = rsp_o_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_cf     = alu_cf_q;

endmodule
